// File: rtl/drc_pwr_seq_if.sv
// Request/status bundle between the CSR block and the camera power sequencer.
// The master side issues cam_en; the sequencer drives the camera controls and the status.
interface drc_pwr_seq_if;
  logic       cam_en;
  logic       cam_pwdn_o;
  logic       cam_rx_en_o;
  logic       dvp_rst_n_o;
  logic       cam_ready_o;
  logic       seq_busy_o;
  logic [2:0] seq_state_o;

  modport master (
    output cam_en,
    input  cam_pwdn_o,
    input  cam_rx_en_o,
    input  dvp_rst_n_o,
    input  cam_ready_o,
    input  seq_busy_o,
    input  seq_state_o
  );

  modport slave (
    input  cam_en,
    output cam_pwdn_o,
    output cam_rx_en_o,
    output dvp_rst_n_o,
    output cam_ready_o,
    output seq_busy_o,
    output seq_state_o
  );
endinterface

// File: rtl/drc_pwr_seq.sv
// Camera power sequencer: turns the cam_en level into timed PWDN / XCLK-enable / RESET
// control with a ready/busy status for firmware.
module drc_pwr_seq #(
  parameter int unsigned T_PWDN_CYC = 125000,
  parameter int unsigned T_XCLK_CYC = 1250,
  parameter int unsigned T_INIT_CYC = 2500000,
  parameter int unsigned T_RST_CYC  = 1250,
  parameter int unsigned T_OFF_CYC  = 1250
) (
  input logic         clk,
  input logic         rst_n,
  drc_pwr_seq_if.slave bus
);

  localparam int unsigned TMaxA = (T_PWDN_CYC > T_XCLK_CYC) ? T_PWDN_CYC : T_XCLK_CYC;
  localparam int unsigned TMaxB = (TMaxA > T_INIT_CYC) ? TMaxA : T_INIT_CYC;
  localparam int unsigned TMaxC = (TMaxB > T_RST_CYC) ? TMaxB : T_RST_CYC;
  localparam int unsigned TMax  = (TMaxC > T_OFF_CYC) ? TMaxC : T_OFF_CYC;
  localparam int unsigned CNT_W = $clog2(TMax) + 1;

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StPwrOn   = 3'd1,
    StXclkOn  = 3'd2,
    StRstRel  = 3'd3,
    StReady   = 3'd4,
    StRstHold = 3'd5,
    StXclkOff = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cam_en_q;
  logic               pwdn_q, pwdn_d;
  logic               rx_en_q, rx_en_d;
  logic               rst_n_q, rst_n_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done;

  assign done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    pwdn_d  = 1'b1;
    rx_en_d = 1'b0;
    rst_n_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;

    // Abort on a dropped request takes priority over timer expiry.
    case (state_q)
      StOff:     if (cam_en_q) state_d = StPwrOn;
      StPwrOn:   if (!cam_en_q) state_d = StOff;
                 else if (done) state_d = StXclkOn;
      StXclkOn:  if (!cam_en_q) state_d = StXclkOff;
                 else if (done) state_d = StRstRel;
      StRstRel:  if (!cam_en_q) state_d = StRstHold;
                 else if (done) state_d = StReady;
      StReady:   if (!cam_en_q) state_d = StRstHold;
      StRstHold: if (done) state_d = StXclkOff;
      StXclkOff: if (done) state_d = StOff;
      default:   state_d = StOff;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        StPwrOn:   cnt_d = CNT_W'(T_PWDN_CYC - 1);
        StXclkOn:  cnt_d = CNT_W'(T_XCLK_CYC - 1);
        StRstRel:  cnt_d = CNT_W'(T_INIT_CYC - 1);
        StRstHold: cnt_d = CNT_W'(T_RST_CYC - 1);
        StXclkOff: cnt_d = CNT_W'(T_OFF_CYC - 1);
        default:   cnt_d = '0;
      endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    case (state_d)
      StPwrOn:   begin pwdn_d = 1'b0; busy_d = 1'b1; end
      StXclkOn:  begin pwdn_d = 1'b0; rx_en_d = 1'b1; busy_d = 1'b1; end
      StRstRel:  begin pwdn_d = 1'b0; rx_en_d = 1'b1; rst_n_d = 1'b1; busy_d = 1'b1; end
      StReady:   begin pwdn_d = 1'b0; rx_en_d = 1'b1; rst_n_d = 1'b1; ready_d = 1'b1; end
      StRstHold: begin pwdn_d = 1'b0; rx_en_d = 1'b1; busy_d = 1'b1; end
      StXclkOff: begin pwdn_d = 1'b0; busy_d = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      cnt_q    <= '0;
      cam_en_q <= 1'b0;
      pwdn_q   <= 1'b1;
      rx_en_q  <= 1'b0;
      rst_n_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cam_en_q <= bus.cam_en;
      pwdn_q   <= pwdn_d;
      rx_en_q  <= rx_en_d;
      rst_n_q  <= rst_n_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cam_pwdn_o  = pwdn_q;
  assign bus.cam_rx_en_o = rx_en_q;
  assign bus.dvp_rst_n_o = rst_n_q;
  assign bus.cam_ready_o = ready_q;
  assign bus.seq_busy_o  = busy_q;
  assign bus.seq_state_o = state_q;

endmodule

// File: tb/tb_drc_pwr_seq.sv
// Scoreboarded bench for drc_pwr_seq: stimulus queues expected output vectors keyed by clock
// edge; a negedge monitor pops and compares them and checks the output invariants.
module tb_drc_pwr_seq;

  localparam logic [7:0] VOff     = 8'b1000_0000;
  localparam logic [7:0] VPwrOn   = 8'b0000_1001;
  localparam logic [7:0] VXclkOn  = 8'b0100_1010;
  localparam logic [7:0] VRstRel  = 8'b0110_1011;
  localparam logic [7:0] VReady   = 8'b0111_0100;
  localparam logic [7:0] VRstHold = 8'b0100_1101;
  localparam logic [7:0] VXclkOff = 8'b0000_1110;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  drc_pwr_seq_if bus ();

  drc_pwr_seq #(
    .T_PWDN_CYC(4),
    .T_XCLK_CYC(3),
    .T_INIT_CYC(5),
    .T_RST_CYC (2),
    .T_OFF_CYC (2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act_vec();
    return {bus.cam_pwdn_o, bus.cam_rx_en_o, bus.dvp_rst_n_o, bus.cam_ready_o,
            bus.seq_busy_o, bus.seq_state_o};
  endfunction

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int c, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    sb_q.push_back(e);
  endfunction

  // Monitor: compare queued expectations on their edge, plus invariants every cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d not compared (now %0d)", e.name, e.cyc, cyc);
      end else begin
        check(e.name, act_vec(), e.vec);
      end
    end
    if (rst_n) begin
      check("inv_rst_needs_xclk", {7'd0, bus.dvp_rst_n_o & ~bus.cam_rx_en_o}, 8'd0);
      check("inv_xclk_needs_pwr", {7'd0, bus.cam_rx_en_o & bus.cam_pwdn_o}, 8'd0);
    end
  end

  task automatic wait_edge(input int e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc != e - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != e - 1) begin
      checks++;
      errors++;
      $display("FAIL wait_edge: got cyc %0d expected %0d", cyc, e - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, k, b2, b3, b4, k2;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.cam_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_vals", act_vec(), VOff);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("idle_after_reset", act_vec(), VOff);

    // Power-up
    b = cyc + 3;
    wait_edge(b);
    bus.cam_en = 1'b1;
    push(b + 1,  VPwrOn,  "up_pwron");
    push(b + 4,  VPwrOn,  "up_pwron_hold");
    push(b + 5,  VXclkOn, "up_xclkon");
    push(b + 7,  VXclkOn, "up_xclkon_hold");
    push(b + 8,  VRstRel, "up_rstrel");
    push(b + 12, VRstRel, "up_rstrel_hold");
    push(b + 13, VReady,  "up_ready");
    push(b + 15, VReady,  "up_ready_hold");

    // Power-down from READY
    k = b + 16;
    wait_edge(k);
    bus.cam_en = 1'b0;
    push(k + 1, VRstHold, "dn_rsthold");
    push(k + 2, VRstHold, "dn_rsthold_hold");
    push(k + 3, VXclkOff, "dn_xclkoff");
    push(k + 4, VXclkOff, "dn_xclkoff_hold");
    push(k + 5, VOff,     "dn_off");
    push(k + 7, VOff,     "dn_off_hold");

    // Abort one cycle into XCLK_ON
    b2 = k + 8;
    wait_edge(b2);
    bus.cam_en = 1'b1;
    push(b2 + 1, VPwrOn,  "abx_pwron");
    push(b2 + 5, VXclkOn, "abx_xclkon");
    wait_edge(b2 + 6);
    bus.cam_en = 1'b0;
    push(b2 + 6, VXclkOn,  "abx_xclkon_hold");
    push(b2 + 7, VXclkOff, "abx_xclkoff");
    push(b2 + 8, VXclkOff, "abx_xclkoff_hold");
    push(b2 + 9, VOff,     "abx_off");

    // Abort in PWR_ON
    b3 = b2 + 11;
    wait_edge(b3);
    bus.cam_en = 1'b1;
    push(b3 + 1, VPwrOn, "abp_pwron");
    wait_edge(b3 + 2);
    bus.cam_en = 1'b0;
    push(b3 + 2, VPwrOn, "abp_pwron_hold");
    push(b3 + 3, VOff,   "abp_off");
    push(b3 + 4, VOff,   "abp_off_hold");

    // Re-request during power-down
    b4 = b3 + 6;
    wait_edge(b4);
    bus.cam_en = 1'b1;
    push(b4 + 13, VReady, "rr_ready");
    k2 = b4 + 15;
    wait_edge(k2);
    bus.cam_en = 1'b0;
    push(k2 + 1, VRstHold, "rr_rsthold");
    wait_edge(k2 + 2);
    bus.cam_en = 1'b1;
    push(k2 + 3,  VXclkOff, "rr_xclkoff");
    push(k2 + 5,  VOff,     "rr_off");
    push(k2 + 6,  VPwrOn,   "rr_pwron");
    push(k2 + 10, VXclkOn,  "rr_xclkon");
    push(k2 + 13, VRstRel,  "rr_rstrel");

    // Async reset in RST_REL, checked before any further clock edge
    wait_edge(k2 + 14);
    #1 rst_n = 1'b0;
    #1 check("async_rst_vals", act_vec(), VOff);
    bus.cam_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("post_async_idle", act_vec(), VOff);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
